// File: rtl/encoder_position_tracker_if.sv
// Signal bundle between the quadrature decoder, encoder_position_tracker and its
// position consumers; the tracker attaches through the slave modport.
interface encoder_position_tracker_if #(
    parameter int W_POS = 9
);
    logic [15:0]      value_in;
    logic             enable;
    logic             preset;
    logic [W_POS-1:0] preset_value;
    logic [W_POS-1:0] position;
    logic             step_up;
    logic             step_down;
    logic             at_min;
    logic             at_max;
    logic             fast;

    modport master (
        output value_in, enable, preset, preset_value,
        input  position, step_up, step_down, at_min, at_max, fast
    );

    modport slave (
        input  value_in, enable, preset, preset_value,
        output position, step_up, step_down, at_min, at_max, fast
    );
endinterface

// File: rtl/encoder_position_tracker.sv
// Turns the decoder's wrapping 16-bit count into a clamped, optionally accelerated
// position with step pulses. Acceleration is built only when ENCODER_ACCEL_EN is defined.
module encoder_position_tracker #(
    parameter int W_POS       = 9,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 479,
    parameter int FAST_WINDOW = 50000,
    parameter int ACCEL_GAIN  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    encoder_position_tracker_if.slave bus
);
    // state   | meaning
    // ST_INIT | first cycle after reset: capture value_in, no motion
    // ST_SLOW | steps move position by |delta|
    // ST_FAST | same-direction steps inside the window move by |delta| * ACCEL_GAIN

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_t;

    // Wide signed arithmetic so |delta| * gain plus position never overflows.
    localparam int AW = W_POS + 20;
    localparam logic signed [AW-1:0] MIN_S  = AW'(POS_MIN);
    localparam logic signed [AW-1:0] MAX_S  = AW'(POS_MAX);
    localparam logic signed [AW-1:0] GAIN_S = AW'(ACCEL_GAIN);

    if (POS_MIN < 0 || POS_MIN > POS_MAX || POS_MAX >= (1 << W_POS) ||
        FAST_WINDOW < 1 || ACCEL_GAIN < 1) begin : g_bad_cfg
        $error("encoder_position_tracker: invalid parameter set");
    end

    function automatic logic [W_POS-1:0] clamp_pos(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
        if (v < MIN_S)      r = MIN_S;
        else if (v > MAX_S) r = MAX_S;
        else                r = v;
        return W_POS'(r);
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      value_q;
    logic [W_POS-1:0] position_q, position_d;
    logic             step_up_q, step_up_d;
    logic             step_down_q, step_down_d;
    logic             at_min_q, at_min_d;
    logic             at_max_q, at_max_d;
    logic             fast_q, fast_d;

    logic signed [15:0]   delta;
    logic signed [AW-1:0] delta_ext;
    logic signed [AW-1:0] mag_ext;
    logic signed [AW-1:0] step_ext;
    logic signed [AW-1:0] pos_ext;
    logic signed [AW-1:0] sum_ext;
    logic signed [AW-1:0] preset_ext;
    logic                 dir_up;
    logic                 running;
    logic                 ev_preset, ev_hold, ev_step, ev_idle;
    logic                 gain_en, go_fast, win_expire;

    assign delta      = bus.value_in - value_q;
    assign delta_ext  = AW'(delta);
    assign mag_ext    = delta_ext[AW-1] ? -delta_ext : delta_ext;
    assign dir_up     = ~delta[15];
    assign pos_ext    = $signed(AW'(position_q));
    assign preset_ext = $signed(AW'(bus.preset_value));
    assign step_ext   = gain_en ? mag_ext * GAIN_S : mag_ext;
    assign sum_ext    = dir_up ? pos_ext + step_ext : pos_ext - step_ext;

    assign running   = (state_q != ST_INIT);
    assign ev_preset = running & bus.preset;
    assign ev_hold   = running & ~bus.preset & ~bus.enable;
    assign ev_step   = running & ~bus.preset & bus.enable & (delta != 16'sd0);
    assign ev_idle   = running & ~bus.preset & bus.enable & (delta == 16'sd0);

`ifdef ENCODER_ACCEL_EN
    localparam int WW = $clog2(FAST_WINDOW + 1);

    logic [WW-1:0] win_cnt_q, win_cnt_d, win_inc;
    logic          last_dir_q, last_dir_d;
    logic          win_open;

    assign win_open   = (win_cnt_q < WW'(FAST_WINDOW));
    assign win_inc    = win_open ? win_cnt_q + 1'b1 : win_cnt_q;
    assign gain_en    = (state_q == ST_FAST) && (dir_up == last_dir_q);
    assign go_fast    = win_open && (dir_up == last_dir_q);
    assign win_expire = ev_idle && (win_inc == WW'(FAST_WINDOW));

    always_comb begin
        win_cnt_d  = win_cnt_q;
        last_dir_d = last_dir_q;
        if (ev_step) begin
            win_cnt_d  = '0;
            last_dir_d = dir_up;
        end else if (ev_hold || ev_idle) begin
            win_cnt_d  = win_inc;
        end
    end

    // Window starts saturated so the first step after reset is always slow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= WW'(FAST_WINDOW);
            last_dir_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            last_dir_q <= last_dir_d;
        end
    end
`else
    assign gain_en    = 1'b0;
    assign go_fast    = 1'b0;
    assign win_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        position_d  = position_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_SLOW;
            default: begin
                if (ev_preset) begin
                    position_d = clamp_pos(preset_ext);
                    state_d    = ST_SLOW;
                end else if (ev_hold) begin
                    state_d    = ST_SLOW;
                end else if (ev_step) begin
                    // Pulses fire even when the clamp leaves the position unchanged.
                    position_d  = clamp_pos(sum_ext);
                    step_up_d   = dir_up;
                    step_down_d = ~dir_up;
                    state_d     = go_fast ? ST_FAST : ST_SLOW;
                end else if (win_expire) begin
                    state_d    = ST_SLOW;
                end
            end
        endcase
        at_min_d = (position_d == W_POS'(POS_MIN));
        at_max_d = (position_d == W_POS'(POS_MAX));
        fast_d   = (state_d == ST_FAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            value_q     <= '0;
            position_q  <= W_POS'(POS_MIN);
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            at_min_q    <= 1'b1;
            at_max_q    <= (POS_MIN == POS_MAX);
            fast_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= bus.value_in;
            position_q  <= position_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            at_min_q    <= at_min_d;
            at_max_q    <= at_max_d;
            fast_q      <= fast_d;
        end
    end

    assign bus.position  = position_q;
    assign bus.step_up   = step_up_q;
    assign bus.step_down = step_down_q;
    assign bus.at_min    = at_min_q;
    assign bus.at_max    = at_max_q;
`ifdef ENCODER_ACCEL_EN
    assign bus.fast      = fast_q;
`else
    assign bus.fast      = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Directed bench for encoder_position_tracker: a cycle reference model compared every
// cycle, plus hand-computed position/pulse expectations for each scenario.
module tb_encoder_position_tracker;
    localparam int W_POS   = 9;
    localparam int POS_MIN = 0;
    localparam int POS_MAX = 479;
    localparam int FW      = 100;
    localparam int GAIN    = 4;
`ifdef ENCODER_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    encoder_position_tracker_if #(.W_POS(W_POS)) bus ();

    encoder_position_tracker #(
        .W_POS(W_POS), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
        .FAST_WINDOW(FW), .ACCEL_GAIN(GAIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cnt_up = 0;
    int cnt_dn = 0;
    bit seen_fast = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < POS_MIN) return POS_MIN;
        if (v > POS_MAX) return POS_MAX;
        return v;
    endfunction

    // Reference model: position as plain integers, window as "cycles since last step".
    int          m_pos;
    bit          m_up, m_dn, m_fast, m_init, m_last;
    int          m_since;
    logic [15:0] m_prev;

    always @(posedge clk or negedge rst_n) begin : ref_model
        int p, d, since, mag;
        bit fst, last, up, dn, dir;
        logic signed [15:0] ds;
        if (!rst_n) begin
            m_pos   <= POS_MIN;
            m_up    <= 1'b0;
            m_dn    <= 1'b0;
            m_fast  <= 1'b0;
            m_init  <= 1'b1;
            m_since <= FW;
            m_last  <= 1'b0;
            m_prev  <= 16'h0;
        end else begin
            p = m_pos; fst = m_fast; since = m_since; last = m_last;
            up = 1'b0; dn = 1'b0;
            ds = bus.value_in - m_prev;
            d  = ds;
            if (!m_init) begin
                if (bus.preset) begin
                    p   = clampi(int'(bus.preset_value));
                    fst = 1'b0;
                end else if (!bus.enable) begin
                    fst   = 1'b0;
                    since = (since < FW) ? since + 1 : FW;
                end else if (d != 0) begin
                    dir = (d > 0);
                    mag = (d > 0) ? d : -d;
                    if (ACC && fst && dir == last) mag = mag * GAIN;
                    p     = clampi(dir ? p + mag : p - mag);
                    up    = dir;
                    dn    = !dir;
                    fst   = ACC && (since < FW) && (dir == last);
                    since = 0;
                    last  = dir;
                end else begin
                    since = (since < FW) ? since + 1 : FW;
                    if (since == FW) fst = 1'b0;
                end
            end
            m_pos   <= p;
            m_up    <= up;
            m_dn    <= dn;
            m_fast  <= fst;
            m_since <= since;
            m_last  <= last;
            m_init  <= 1'b0;
            m_prev  <= bus.value_in;
        end
    end

    always @(posedge clk) begin
        logic [W_POS+4:0] act_v, exp_v;
        #1;
        act_v = {bus.position, bus.step_up, bus.step_down, bus.at_min, bus.at_max, bus.fast};
        exp_v = {W_POS'(m_pos), m_up, m_dn, (m_pos == POS_MIN), (m_pos == POS_MAX), m_fast};
        check("cycle_outputs", int'(act_v), int'(exp_v));
        if (bus.step_up)   cnt_up++;
        if (bus.step_down) cnt_dn++;
        if (bus.fast)      seen_fast = 1'b1;
    end

    task automatic do_step(input int dv, input int spacing, output int pos_after, output int fast_after);
        bus.value_in = bus.value_in + 16'(dv);
        @(negedge clk);
        pos_after  = bus.position;
        fast_after = bus.fast;
        repeat (spacing - 1) @(negedge clk);
    endtask

    task automatic do_preset(input int v);
        bus.preset       = 1'b1;
        bus.preset_value = W_POS'(v);
        @(negedge clk);
        bus.preset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p[5];
        int f[5];
        bus.value_in     = 16'h1234;
        bus.enable       = 1'b1;
        bus.preset       = 1'b0;
        bus.preset_value = '0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_position", bus.position, 0);
        check("reset_at_min", bus.at_min, 1);
        check("reset_at_max", bus.at_max, 0);
        check("reset_fast", bus.fast, 0);

        // Reset recapture: value_in already 0x1234 at release must not produce a step.
        rst_n  = 1'b1;
        cnt_up = 0; cnt_dn = 0;
        repeat (10) @(negedge clk);
        check("recapture_position", bus.position, 0);
        check("recapture_pulses", cnt_up + cnt_dn, 0);
        check("recapture_at_min", bus.at_min, 1);

        // Slow stepping: spacing beyond the window keeps gain 1.
        cnt_up = 0; seen_fast = 1'b0;
        for (int i = 0; i < 5; i++) do_step(1, 120, p[0], f[0]);
        check("slow_position", bus.position, 5);
        check("slow_up_pulses", cnt_up, 5);
        check("slow_fast_seen", int'(seen_fast), 0);

        // Acceleration: four +1 steps 20 cycles apart, then a reversal.
        do_preset(0);
        for (int i = 0; i < 4; i++) do_step(1, 20, p[i], f[i]);
        do_step(-1, 120, p[4], f[4]);
`ifdef ENCODER_ACCEL_EN
        check("accel_pos1", p[0], 1);
        check("accel_pos2", p[1], 2);
        check("accel_pos3", p[2], 6);
        check("accel_pos4", p[3], 10);
        check("accel_fast_after_step2", f[1], 1);
        check("accel_fast_step4", f[3], 1);
        check("accel_reverse_pos", p[4], 9);
        check("accel_reverse_fast", f[4], 0);
`else
        check("noaccel_pos1", p[0], 1);
        check("noaccel_pos2", p[1], 2);
        check("noaccel_pos3", p[2], 3);
        check("noaccel_pos4", p[3], 4);
        check("noaccel_fast", f[3], 0);
        check("noaccel_reverse_pos", p[4], 3);
`endif

        // enable=0 discards motion; re-enabling does not replay it.
        bus.enable   = 1'b0;
        bus.value_in = bus.value_in + 16'd7;
        repeat (3) @(negedge clk);
        check("disabled_hold", bus.position, ACC ? 9 : 3);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reenabled_hold", bus.position, ACC ? 9 : 3);

        // Wrap through 0xFFFF/0x0000.
        bus.value_in = 16'hFFFE;
        do_preset(100);
        cnt_up = 0; cnt_dn = 0;
        do_step(1, 120, p[0], f[0]);
        do_step(1, 120, p[1], f[1]);
        do_step(-1, 120, p[2], f[2]);
        check("wrap_value", int'(bus.value_in), 16'hFFFF);
        check("wrap_pos_after_up", p[0], 101);
        check("wrap_pos_final", bus.position, 101);
        check("wrap_up_pulses", cnt_up, 2);
        check("wrap_down_pulses", cnt_dn, 1);

        // Upper clamp: pulses still fire while pinned at POS_MAX.
        do_preset(477);
        cnt_up = 0;
        for (int i = 0; i < 5; i++) do_step(1, 120, p[0], f[0]);
        check("clamp_position", bus.position, 479);
        check("clamp_at_max", bus.at_max, 1);
        check("clamp_up_pulses", cnt_up, 5);
        do_step(-1, 120, p[0], f[0]);
        check("clamp_release_pos", p[0], 478);
        check("clamp_release_at_max", bus.at_max, 0);

        // Async reset while accelerated.
        do_preset(194);
        for (int i = 0; i < 3; i++) do_step(1, 20, p[i], f[i]);
        repeat (3) @(negedge clk);
`ifdef ENCODER_ACCEL_EN
        check("prereset_position", bus.position, 200);
        check("prereset_fast", bus.fast, 1);
`else
        check("prereset_position", bus.position, 197);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_position", bus.position, 0);
        check("async_reset_fast", bus.fast, 0);
        check("async_reset_at_min", bus.at_min, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_step(3, 5, p[0], f[0]);
        check("post_reset_step", p[0], 3);
        check("post_reset_fast", f[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/encoder_position_tracker.md
# encoder_position_tracker

Converts the free-running 16-bit count from the quadrature decoder into a clamped, optionally accelerated screen/menu position. It sits directly downstream of the decoder and upstream of the LCD, TM1638 and LED consumers. It turns raw wrap-around counts into bounded coordinates, such as an LCD column in 0..479, plus per-step event pulses.

## Interface
Parameters:
- `W_POS`, 9: position width.
- `POS_MIN`, 0: lower clamp bound.
- `POS_MAX`, 479: upper clamp bound. Requires POS_MIN ≤ POS_MAX < 2^W_POS.
- `FAST_WINDOW`, 50000: cycles after a step during which the next same-direction step qualifies as fast.
- `ACCEL_GAIN`, 4: step multiplier while in FAST state.

Ports:
- `clk`, in, 1: system clock. This is the block's only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `value_in`, in, 16: count from the decoder, synchronous to clk.
- `enable`, in, 1: when 0, motion is discarded.
- `preset`, in, 1: single-cycle load request.
- `preset_value`, in, W_POS: value loaded on preset, clamped.
- `position`, out, W_POS: registered clamped position.
- `step_up`, out, 1: 1-cycle pulse on detected positive motion.
- `step_down`, out, 1: 1-cycle pulse on detected negative motion.
- `at_min`, out, 1: registered flag, position == POS_MIN.
- `at_max`, out, 1: registered flag, position == POS_MAX.
- `fast`, out, 1: registered flag, state == FAST.

## Operation
States are INIT, SLOW and FAST. Internal registers:
- `value_q` (16 bits)
- `win_cnt`, saturating at FAST_WINDOW
- `last_dir` (1 bit)

Reset values:
- position = POS_MIN
- at_min = 1 if POS_MIN == POS_MAX, else as computed (always 1 at reset), at_max = (POS_MIN == POS_MAX)
- step_up = step_down = fast = 0
- state = INIT
- win_cnt = FAST_WINDOW
- last_dir = 0

Delta computation: delta = value_in − value_q, modulo 2^16, interpreted as signed 16-bit. So 0xFFFF→0x0000 gives +1 and 0x0000→0xFFFF gives −1. value_q ← value_in every cycle outside reset.

INIT state:
- Captures value_in into value_q.
- Produces no motion and no pulses.
- Goes to SLOW unconditionally on the next cycle.

SLOW/FAST state, one evaluation per cycle, applied in priority order:
1. preset: position ← clamp(preset_value). The delta is discarded, there are no pulses, and state ← SLOW.
2. enable=0: the delta is discarded, there are no pulses, position is held, state ← SLOW, and win_cnt increments (saturating).
3. delta ≠ 0: this is a step.
   - Direction is up if delta > 0.
   - Step magnitude mag = |delta| × (state==FAST and dir==last_dir ? ACCEL_GAIN : 1).
   - position ← clamp(position ± mag). Arithmetic is at least W_POS+19 bits signed, so no intermediate overflow occurs.
   - step_up or step_down pulses even when the position is already clamped.
   - Next state is FAST if win_cnt < FAST_WINDOW and dir == last_dir; otherwise SLOW.
   - win_cnt ← 0 and last_dir ← dir.
4. delta = 0: win_cnt increments. When it reaches FAST_WINDOW, state ← SLOW.

Boundary conditions:
- Reversal in FAST: that step uses gain 1 and the state falls to SLOW.
- The first step after reset is always SLOW, because win_cnt starts saturated.
- Clamping is exact at both bounds. There is no wrap of position.

## Timing
- Latency: a change on value_in at cycle N appears on position, the step pulses, at_min/at_max and fast at cycle N+1, all registered together.
- preset: takes effect on position at N+1.
- rst_n assertion: forces all outputs to their reset values immediately, regardless of clk. This holds mid-step and in FAST.
- rst_n deassertion: takes effect synchronously. The first clk edge after release enters INIT, and no spurious step occurs regardless of the value_in value.
- value_in must come from the clk domain, which is the decoder's output. There is no internal synchronizer.

## Configuration
`ENCODER_ACCEL_EN`:
- Defined: the FAST state, win_cnt, last_dir and ACCEL_GAIN behave as above.
- Undefined: FAST is never entered, fast is tied to 0, win_cnt and last_dir are removed, and every step uses gain 1. FAST_WINDOW and ACCEL_GAIN are ignored.

## Test plan
- **Reset recapture:** set value_in=0x1234 during reset, then release and hold for 10 cycles. Required: position=0, no pulses, at_min=1.
- **Slow stepping:** FAST_WINDOW=100; apply value_in +1 every 120 cycles, 5 times. Required: position=5, 5 step_up pulses, fast never asserted.
- **Acceleration (macro defined):** FAST_WINDOW=100; apply +1 every 20 cycles, 4 times. Required: positions 1, 2, 6, 10 and fast=1 from the cycle after step 2. Then apply −1. Required: position=9 and fast=0.
- **Wrap:** sequence value_in 0xFFFE→0xFFFF→0x0000→0xFFFF. Required: step_up, step_up, step_down, and position returns to its start+1.
- **Clamp:** preset 477, then five slow +1 steps. Required: position=479, at_max=1, 5 step_up pulses. Then −1. Required: position=478 and at_max=0.
- **Async reset mid-FAST:** while fast=1 and position=200, drop rst_n between clock edges. Required: position=0 and fast=0 immediately. After release, a value_in change of +3 yields position=3.
